// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - key debounce, long-press/auto-repeat detection and clock set-mode FSM
// Per-key sync/debounce feeds a six-state edit FSM whose outputs are all registered.
module key_mode_ctrl #(
  parameter int MCNT_F   = 1_000_000,
  parameter int MCNT_2S  = 100_000_000,
  parameter int MCNT_RPT = 10_000_000,
  parameter int MCNT_TO  = 500_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Key,
  output logic       Set_En,
  output logic       Alarm_Sel,
  output logic [2:0] Field,
  output logic       Inc_Pulse,
  output logic       Dec_Pulse,
  output logic       Commit,
  output logic [3:0] LED
);

  localparam int FW = $clog2(MCNT_F + 1);
  localparam int HW = $clog2(MCNT_2S + 1);
  localparam int RW = $clog2(MCNT_RPT + 1);
  localparam int TW = $clog2(MCNT_TO + 1);

  typedef enum logic [2:0] {RUN, T_HOUR, T_MIN, T_SEC, A_HOUR, A_MIN} state_t;

  logic [3:0] press, rel;
  logic [2:0] long_hit;
  logic [1:0] rpt_hit;
  logic       alarm_short;
  logic       inc_low;

  // Key index: 3 MODE, 2 ALARM, 1 INC, 0 DEC
  for (genvar i = 0; i < 4; i++) begin : g_key
    logic          s1, s2, lvl, flip, press_r, rel_r;
    logic [FW-1:0] db_cnt;

    assign flip = (s2 != lvl) && (db_cnt == FW'(MCNT_F - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        s1      <= 1'b1;
        s2      <= 1'b1;
        lvl     <= 1'b1;
        db_cnt  <= '0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        s1      <= Key[i];
        s2      <= s1;
        db_cnt  <= (s2 == lvl || flip) ? '0 : db_cnt + 1'b1;
        if (flip) lvl <= s2;
        press_r <= flip & lvl;
        rel_r   <= flip & ~lvl;
      end
    end

    assign press[i] = press_r;
    assign rel[i]   = rel_r;

    if (i < 3) begin : g_hold
      logic [HW-1:0] hold;
      logic          sat, long_r;

      assign sat = (hold == HW'(MCNT_2S));

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          hold   <= '0;
          long_r <= 1'b0;
        end else begin
          if (lvl) hold <= '0;
          else if (!sat) hold <= hold + 1'b1;
          long_r <= ~lvl & (hold == HW'(MCNT_2S - 1));
        end
      end

      assign long_hit[i] = long_r;

      if (i < 2) begin : g_rpt
        logic [RW-1:0] rpt;
        logic          rpt_r;

        // A release landing on a repeat boundary wins over the repeat
        always_ff @(posedge Clk or negedge Reset_n) begin
          if (!Reset_n) begin
            rpt   <= '0;
            rpt_r <= 1'b0;
          end else begin
            if (~lvl & sat) rpt <= (rpt == RW'(MCNT_RPT - 1)) ? '0 : rpt + 1'b1;
            else rpt <= '0;
            rpt_r <= ~lvl & sat & (rpt == RW'(MCNT_RPT - 1)) & ~flip;
          end
        end

        assign rpt_hit[i] = rpt_r;
        if (i == 1) begin : g_inc_lvl
          assign inc_low = ~lvl;
        end
      end else begin : g_short
        // Hold still below threshold in the release cycle means the long hit never fired
        assign alarm_short = rel_r & (hold < HW'(MCNT_2S));
      end
    end
  end

  state_t        state, nxt;
  logic [TW-1:0] to_cnt;
  logic          commit_n, inc_n, dec_n, in_set, inc_ev, dec_ev;
  logic [2:0]    field_n;
  logic [1:0]    idx_n;

  assign in_set = (state != RUN);
  assign inc_ev = press[1] | long_hit[1] | rpt_hit[1];
  assign dec_ev = (press[0] | long_hit[0] | rpt_hit[0]) & ~inc_low;

  always_comb begin
    nxt      = state;
    inc_n    = 1'b0;
    dec_n    = 1'b0;
    if (press[3]) begin
      case (state)
        RUN:     nxt = T_HOUR;
        T_HOUR:  nxt = T_MIN;
        T_MIN:   nxt = T_SEC;
        A_HOUR:  nxt = A_MIN;
        default: nxt = RUN;
      endcase
    end else if (alarm_short) begin
      nxt = (state == A_HOUR || state == A_MIN) ? T_HOUR : A_HOUR;
    end else if (long_hit[2] && in_set) begin
      nxt = RUN;
    end else if (in_set && to_cnt == TW'(MCNT_TO - 1)) begin
      nxt = RUN;
    end else if (in_set && inc_ev) begin
      inc_n = 1'b1;
    end else if (in_set && dec_ev) begin
      dec_n = 1'b1;
    end
    commit_n = in_set && (nxt == RUN);

    field_n = 3'b000;
    idx_n   = 2'b00;
    case (nxt)
      T_HOUR, A_HOUR: field_n = 3'b100;
      T_MIN, A_MIN: begin
        field_n = 3'b010;
        idx_n   = 2'b01;
      end
      T_SEC: begin
        field_n = 3'b001;
        idx_n   = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= RUN;
      to_cnt    <= '0;
      Set_En    <= 1'b0;
      Alarm_Sel <= 1'b0;
      Field     <= 3'b000;
      Inc_Pulse <= 1'b0;
      Dec_Pulse <= 1'b0;
      Commit    <= 1'b0;
      LED       <= 4'b0000;
    end else begin
      state     <= nxt;
      to_cnt    <= (!in_set || (|press) || (|rel)) ? '0 : to_cnt + 1'b1;
      Set_En    <= (nxt != RUN);
      Alarm_Sel <= (nxt == A_HOUR || nxt == A_MIN);
      Field     <= field_n;
      Inc_Pulse <= inc_n;
      Dec_Pulse <= dec_n;
      Commit    <= commit_n;
      LED       <= {nxt != RUN, nxt == A_HOUR || nxt == A_MIN, idx_n};
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb/tb_key_mode_ctrl.sv - directed self-checking bench for key_mode_ctrl
module tb_key_mode_ctrl;
  localparam int MCNT_F = 4, MCNT_2S = 40, MCNT_RPT = 10, MCNT_TO = 300;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Key;
  logic       Set_En, Alarm_Sel, Inc_Pulse, Dec_Pulse, Commit;
  logic [2:0] Field;
  logic [3:0] LED;

  key_mode_ctrl #(
    .MCNT_F(MCNT_F), .MCNT_2S(MCNT_2S), .MCNT_RPT(MCNT_RPT), .MCNT_TO(MCNT_TO)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Key(Key), .Set_En(Set_En), .Alarm_Sel(Alarm_Sel),
    .Field(Field), .Inc_Pulse(Inc_Pulse), .Dec_Pulse(Dec_Pulse), .Commit(Commit), .LED(LED)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int inc_cnt = 0, dec_cnt = 0, com_cnt = 0, com_cyc = 0, dec_cyc = 0;
  int inc_at [0:63];
  always @(negedge Clk) begin
    if (Inc_Pulse) begin
      if (inc_cnt < 64) inc_at[inc_cnt] <= cyc;
      inc_cnt <= inc_cnt + 1;
    end
    if (Dec_Pulse) begin
      dec_cnt <= dec_cnt + 1;
      dec_cyc <= cyc;
    end
    if (Commit) begin
      com_cnt <= com_cnt + 1;
      com_cyc <= cyc;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_mode();
    Key[3] = 1'b0;
    tick(20);
    Key[3] = 1'b1;
    tick(20);
  endtask

  int c0, n_inc, n_dec, n_com;
  logic [15:0] led_seq;
  logic [11:0] fld_seq;

  initial begin
    Reset_n = 1'b1;
    Key     = 4'hF;
    @(negedge Clk);
    Reset_n = 1'b0;
    tick(3);
    check("reset_outs", 32'({Set_En, Alarm_Sel, Field, Inc_Pulse, Dec_Pulse, Commit, LED}), 32'd0);
    Reset_n = 1'b1;
    tick(5);

    // MODE x4 walks the time fields and returns to RUN
    led_seq = 16'b1000_1001_1010_0000;
    fld_seq = 12'b100_010_001_000;
    n_com   = com_cnt;
    for (int i = 0; i < 4; i++) begin
      Key[3] = 1'b0;
      tick(20);
      check($sformatf("mode%0d_led", i), 32'(LED), 32'(led_seq[15-4*i -: 4]));
      check($sformatf("mode%0d_field", i), 32'(Field), 32'(fld_seq[11-3*i -: 3]));
      check($sformatf("mode%0d_commit", i), 32'(com_cnt - n_com), (i == 3) ? 32'd1 : 32'd0);
      Key[3] = 1'b1;
      tick(20);
    end

    // Glitch shorter than the debounce window
    Key[3] = 1'b0;
    tick(3);
    Key[3] = 1'b1;
    tick(20);
    check("glitch_led", 32'(LED), 32'd0);

    // ALARM short from RUN, then long hold inside A_HOUR
    n_com  = com_cnt;
    Key[2] = 1'b0;
    tick(15);
    Key[2] = 1'b1;
    tick(20);
    check("alarm_short_led", 32'(LED), 32'b1100);
    check("alarm_short_field", 32'(Field), 32'b100);
    check("alarm_short_commit", 32'(com_cnt - n_com), 32'd0);
    c0     = cyc;
    Key[2] = 1'b0;
    tick(60);
    check("alarm_long_commit", 32'(com_cnt - n_com), 32'd1);
    check("alarm_long_cyc", 32'(com_cyc - c0), 32'd47);
    check("alarm_long_led", 32'(LED), 32'd0);
    Key[2] = 1'b1;
    tick(20);
    check("alarm_rel_led", 32'(LED), 32'd0);
    check("alarm_rel_commit", 32'(com_cnt - n_com), 32'd1);

    // MODE and INC together in T_HOUR: MODE wins
    press_mode();
    n_inc = inc_cnt;
    Key   = 4'b0101;
    tick(20);
    Key   = 4'hF;
    tick(20);
    check("mode_inc_led", 32'(LED), 32'b1001);
    check("mode_inc_pulses", 32'(inc_cnt - n_inc), 32'd0);

    // INC held 80 cycles in T_MIN: press pulse plus long and repeats
    n_inc  = inc_cnt;
    n_dec  = dec_cnt;
    c0     = cyc;
    Key[1] = 1'b0;
    tick(80);
    Key[1] = 1'b1;
    tick(30);
    check("inc_hold_count", 32'(inc_cnt - n_inc), 32'd5);
    check("inc_press_lat", 32'(inc_at[n_inc] - c0), 32'd7);
    for (int k = 1; k < 5; k++)
      check($sformatf("inc_rep%0d", k), 32'(inc_at[n_inc+k] - inc_at[n_inc]), 32'(30 + 10 * k));
    check("inc_hold_dec", 32'(dec_cnt - n_dec), 32'd0);
    check("inc_hold_led", 32'(LED), 32'b1001);

    // DEC single press
    n_dec  = dec_cnt;
    c0     = cyc;
    Key[0] = 1'b0;
    tick(20);
    Key[0] = 1'b1;
    tick(20);
    check("dec_count", 32'(dec_cnt - n_dec), 32'd1);
    check("dec_lat", 32'(dec_cyc - c0), 32'd7);

    // DEC pressed while INC already held is suppressed
    n_inc  = inc_cnt;
    n_dec  = dec_cnt;
    Key[1] = 1'b0;
    tick(2);
    Key[0] = 1'b0;
    tick(20);
    Key    = 4'hF;
    tick(20);
    check("both_inc", 32'(inc_cnt - n_inc), 32'd1);
    check("both_dec", 32'(dec_cnt - n_dec), 32'd0);

    press_mode();
    check("tsec_led", 32'(LED), 32'b1010);
    press_mode();
    check("back_run_led", 32'(LED), 32'd0);

    // Inactivity timeout in T_HOUR
    n_com  = com_cnt;
    c0     = cyc;
    Key[3] = 1'b0;
    tick(20);
    Key[3] = 1'b1;
    tick(290);
    check("to_before_led", 32'(LED), 32'b1000);
    tick(40);
    check("to_commit", 32'(com_cnt - n_com), 32'd1);
    check("to_cyc", 32'(com_cyc - c0), 32'd327);
    check("to_led", 32'(LED), 32'd0);

    // Reset during an INC hold in T_HOUR
    press_mode();
    check("pre_rst_led", 32'(LED), 32'b1000);
    n_com   = com_cnt;
    Key[1]  = 1'b0;
    tick(30);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({Set_En, Alarm_Sel, Field, Inc_Pulse, Dec_Pulse, Commit, LED}), 32'd0);
    tick(3);
    Reset_n = 1'b1;
    tick(20);
    check("post_rst_led", 32'(LED), 32'd0);
    check("post_rst_commit", 32'(com_cnt - n_com), 32'd0);
    Key[1] = 1'b1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Key-driven mode/setting controller for the electric clock. It debounces the four raw board keys and detects short press, long press and auto-repeat. A six-state FSM tells the timekeeping and alarm datapath which field is being edited and when to increment, decrement or commit. It sits between the board keys and the time/alarm counter registers; the display driver reads its field select for blinking.

## Interface
Parameters:
- MCNT_F, 1_000_000, debounce stability count in Clk cycles (20 ms at 50 MHz)
- MCNT_2S, 100_000_000, long-press threshold in cycles (2 s)
- MCNT_RPT, 10_000_000, auto-repeat interval after long press (200 ms)
- MCNT_TO, 500_000_000, inactivity timeout in set states (10 s)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- Key  in  4  raw keys, active-low: [3] MODE, [2] ALARM, [1] INC, [0] DEC
- Set_En  out  1  high in any set state; datapath freezes second counting of the edited group
- Alarm_Sel  out  1  0 = time registers targeted, 1 = alarm registers
- Field  out  3  one-hot edited field: [2] hour, [1] min, [0] sec; 000 in RUN
- Inc_Pulse  out  1  one-cycle increment strobe for the selected field
- Dec_Pulse  out  1  one-cycle decrement strobe for the selected field
- Commit  out  1  one-cycle strobe on every exit to RUN
- LED  out  4  [3] = Set_En, [2] = Alarm_Sel, [1:0] = field index (00 hour, 01 min, 10 sec)

## Operation
- Per key: 2-FF synchroniser, then debounce counter. The counter increments while the synchronised level differs from the stable level, else clears. At count MCNT_F-1 the stable level flips. A press event is a stable 1->0 transition; a release event is 0->1.
- Hold counter per key runs while stable-low and saturates at MCNT_2S.
- States: RUN, T_HOUR, T_MIN, T_SEC, A_HOUR, A_MIN.
- MODE press: RUN->T_HOUR->T_MIN->T_SEC->RUN; A_HOUR->A_MIN->RUN. Commit pulses on each ->RUN.
- ALARM handling:
  - Resolved at release if held < MCNT_2S (short press).
  - Short press: RUN->A_HOUR; T_*->A_HOUR; A_*->T_HOUR.
  - Hold reaching MCNT_2S in a set state: immediate ->RUN with Commit; the later release is ignored.
  - Long hold in RUN: no action.
- INC/DEC, set states only:
  - Press emits one pulse.
  - If held, further pulses at hold = MCNT_2S, then every MCNT_RPT cycles until release.
  - Ignored in RUN.
- Simultaneous events in the same cycle: priority MODE > ALARM > INC > DEC; lower events that cycle are dropped. If INC and DEC are both stable-low, DEC pulses are suppressed.
- The timeout counter clears on any press/release event. In a set state, reaching MCNT_TO-1 forces ->RUN with Commit. It does not run in RUN.
- Inc_Pulse and Dec_Pulse are never high in the same cycle as a state change or Commit.

## Timing
- Reset (async assert, sync release):
  - State = RUN; all outputs 0.
  - Debounce stable levels = 1; all counters = 0.
- Latency: a clean raw edge reaches its event and the output change in MCNT_F+3 cycles (2 sync, MCNT_F debounce, 1 output register).
- All outputs are registered; strobes are exactly 1 cycle wide.
- Field, Alarm_Sel and LED update in the same cycle as the state register.
- A glitch shorter than MCNT_F cycles produces no event.
- Auto-repeat spacing is exactly MCNT_RPT cycles between Inc_Pulse rising edges.
- Reset mid-hold or mid-edit returns to RUN with no Commit; a key still held at reset release produces a press event after MCNT_F+3 cycles.

## Test plan
Bench uses MCNT_F=4, MCNT_2S=40, MCNT_RPT=10, MCNT_TO=300, 20 ns clock.
- MODE press ×4 (each held 20 cycles, 20 released) -> LED 1000, 1001, 1010, 0000; Commit exactly once, on the 4th press; Field 100, 010, 001, 000.
- In T_MIN, INC held 80 cycles -> Inc_Pulse at press+7, then at hold 40, 50, 60, 70 (5 pulses), none after release; Dec_Pulse stays 0.
- ALARM held 15 cycles from RUN -> A_HOUR after release (LED 1100). ALARM held 60 cycles -> RUN with Commit when hold hits 40; release causes no change.
- 3-cycle low glitch on MODE -> no state change. MODE and INC pressed in the same cycle in T_HOUR -> T_MIN, no Inc_Pulse.
- Enter T_HOUR and idle 300 cycles -> RUN with one Commit pulse. Reset_n asserted mid-INC-hold -> all outputs 0 immediately.
